cnn_layer_accel_awe_stride_expander: RTL and testbench

Zero-insertion upsampler for the AWE datapath: re-expands a compact pixel stream to the strided grid that transposed-convolution layers need, the inverse of stride decimation. Each accepted input sample is followed by `stride_size` zero columns, and each input row by `stride_size` zero rows. It sits between the input buffer read port and the AWE window-formation logic and uses valid/ready handshakes on both sides.

---
 rtl/cnn_layer_accel_awe_pkg.sv | 20 ++
 rtl/cnn_layer_accel_awe_out_reg.sv | 43 ++++
 rtl/cnn_layer_accel_awe_stride_expander.sv | 211 +++++++++++++++++++++
 tb/tb_cnn_layer_accel_awe_stride_expander.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared types and width constants for the AWE stride expander.
//
// MAX_STRIDE is the largest stride the accelerator is built for. It is
// mirrored here so the width constants below can be derived from it.
// Stride fields are clog2(MAX_STRIDE) bits wide.
package cnn_layer_accel_awe_pkg;

    localparam int MAX_STRIDE   = 8;
    localparam int STRIDE_CNT_W = $clog2(MAX_STRIDE);
    localparam int ROW_LEN_W    = 10;
    localparam int DATA_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_ZERO_COL,
        ST_ZERO_ROW
    } awe_stride_exp_state_t;

endpackage

// File: rtl/cnn_layer_accel_awe_out_reg.sv
// Single-entry valid/ready output register holding data, valid and last.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clear           - drop any held word (used on reconfiguration)
//   load            - capture load_data/load_last; only asserted by the
//                     owner when the register is empty or being drained
//   load_data/last  - word to capture
//   out_ready       - downstream accepts the held word
//   out_data/valid/last - registered output
module cnn_layer_accel_awe_out_reg
    import cnn_layer_accel_awe_pkg::*;
#(
    parameter int C_DATA_WIDTH = DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [C_DATA_WIDTH-1:0] load_data,
    input  logic                    load_last,
    input  logic                    out_ready,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/cnn_layer_accel_awe_stride_expander.sv
// Zero-insertion upsampler for the AWE datapath. Each accepted sample is
// followed by stride_size zero words (except at row end and after the
// frame's last sample). With AWE_STRIDE_EXPANDER_ZERO_ROW_EN defined, each
// input row (except the one holding datain_last) is also followed by
// stride_size zero rows of (row_length-1)*(stride_size+1)+1 words.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   config_valid                  - load stride_size/row_length, restart
//   stride_size, row_length       - expansion configuration
//   datain, datain_valid,
//   datain_last, datain_ready     - compact input stream
//   dataout, dataout_valid,
//   dataout_last, dataout_ready   - expanded output stream (one reg stage)
//
// state       | meaning
// ST_IDLE     | unconfigured, no input accepted
// ST_SAMPLE   | waiting for an input sample
// ST_ZERO_COL | emitting zero columns after a non-row-end sample
// ST_ZERO_ROW | emitting zero rows after a row end
module cnn_layer_accel_awe_stride_expander
    import cnn_layer_accel_awe_pkg::*;
#(
    parameter int C_DATA_WIDTH           = DATA_W,
    parameter int C_ROW_LEN_WIDTH        = ROW_LEN_W,
    parameter int C_STRIDE_COUNTER_WIDTH = STRIDE_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              config_valid,
    input  logic [C_STRIDE_COUNTER_WIDTH-1:0] stride_size,
    input  logic [C_ROW_LEN_WIDTH-1:0]        row_length,
    input  logic [C_DATA_WIDTH-1:0]           datain,
    input  logic                              datain_valid,
    input  logic                              datain_last,
    output logic                              datain_ready,
    output logic [C_DATA_WIDTH-1:0]           dataout,
    output logic                              dataout_valid,
    output logic                              dataout_last,
    input  logic                              dataout_ready
);

    localparam logic [C_ROW_LEN_WIDTH-1:0]        ROW_ONE    = 1;
    localparam logic [C_STRIDE_COUNTER_WIDTH-1:0] STRIDE_ONE = 1;

    awe_stride_exp_state_t state_q, state_d;

    logic [C_STRIDE_COUNTER_WIDTH-1:0] stride_q, stride_d;
    logic [C_ROW_LEN_WIDTH-1:0]        row_len_q, row_len_d;
    logic [C_ROW_LEN_WIDTH-1:0]        col_cnt, col_cnt_d;
    logic [C_STRIDE_COUNTER_WIDTH-1:0] zero_cnt, zero_cnt_d;

`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
    localparam int ZW = C_ROW_LEN_WIDTH + C_STRIDE_COUNTER_WIDTH;
    logic [ZW-1:0]                     zrow_word_cnt, zrow_word_cnt_d;
    logic [C_STRIDE_COUNTER_WIDTH-1:0] zrow_cnt, zrow_cnt_d;
    logic [ZW-1:0]                     zrow_last_idx;

    // Index of the final word in a zero row: (row_len-1)*(stride+1).
    // ZW bits hold the worst case without wrapping.
    always_comb begin
        zrow_last_idx = (ZW'(row_len_q) - ZW'(1)) * (ZW'(stride_q) + ZW'(1));
    end
`endif

    logic advance;
    logic row_end;
    logic datain_accept;
    logic out_load;
    logic out_clear;
    logic [C_DATA_WIDTH-1:0] out_data;
    logic out_last;

    // Output register can take a new word this cycle.
    assign advance       = !dataout_valid || dataout_ready;
    assign row_end       = (col_cnt == (row_len_q - ROW_ONE));
    // Blocked during config_valid so a sample is never handshaked and then
    // discarded by the restart.
    assign datain_ready  = (state_q == ST_SAMPLE) && advance && !config_valid;
    assign datain_accept = datain_valid && datain_ready;

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        row_len_d  = row_len_q;
        col_cnt_d  = col_cnt;
        zero_cnt_d = zero_cnt;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
        zrow_word_cnt_d = zrow_word_cnt;
        zrow_cnt_d      = zrow_cnt;
`endif
        out_load  = 1'b0;
        out_clear = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        if (config_valid) begin
            state_d    = ST_SAMPLE;
            stride_d   = stride_size;
            row_len_d  = (row_length == '0) ? ROW_ONE : row_length;
            col_cnt_d  = '0;
            zero_cnt_d = '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
            zrow_word_cnt_d = '0;
            zrow_cnt_d      = '0;
`endif
            out_clear = 1'b1;
        end else begin
            case (state_q)
                ST_SAMPLE: begin
                    if (datain_accept) begin
                        out_load = 1'b1;
                        out_data = datain;
                        out_last = datain_last;
                        // Nothing follows the frame's last sample, so
                        // dataout_last really is the final word.
                        if (datain_last) begin
                            col_cnt_d = '0;
                        end else if (row_end) begin
                            col_cnt_d = '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
                            if (stride_q != '0)
                                state_d = ST_ZERO_ROW;
`endif
                        end else begin
                            col_cnt_d = col_cnt + ROW_ONE;
                            if (stride_q != '0)
                                state_d = ST_ZERO_COL;
                        end
                    end
                end
                ST_ZERO_COL: begin
                    if (advance) begin
                        out_load = 1'b1;
                        if (zero_cnt == (stride_q - STRIDE_ONE)) begin
                            zero_cnt_d = '0;
                            state_d    = ST_SAMPLE;
                        end else begin
                            zero_cnt_d = zero_cnt + STRIDE_ONE;
                        end
                    end
                end
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
                ST_ZERO_ROW: begin
                    if (advance) begin
                        out_load = 1'b1;
                        if (zrow_word_cnt == zrow_last_idx) begin
                            zrow_word_cnt_d = '0;
                            if (zrow_cnt == (stride_q - STRIDE_ONE)) begin
                                zrow_cnt_d = '0;
                                state_d    = ST_SAMPLE;
                            end else begin
                                zrow_cnt_d = zrow_cnt + STRIDE_ONE;
                            end
                        end else begin
                            zrow_word_cnt_d = zrow_word_cnt + ZW'(1);
                        end
                    end
                end
`endif
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q  <= '0;
            row_len_q <= ROW_ONE;
            col_cnt   <= '0;
            zero_cnt  <= '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
            zrow_word_cnt <= '0;
            zrow_cnt      <= '0;
`endif
        end else begin
            stride_q  <= stride_d;
            row_len_q <= row_len_d;
            col_cnt   <= col_cnt_d;
            zero_cnt  <= zero_cnt_d;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
            zrow_word_cnt <= zrow_word_cnt_d;
            zrow_cnt      <= zrow_cnt_d;
`endif
        end
    end

    cnn_layer_accel_awe_out_reg #(
        .C_DATA_WIDTH(C_DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .clear     (out_clear),
        .load      (out_load),
        .load_data (out_data),
        .load_last (out_last),
        .out_ready (dataout_ready),
        .out_data  (dataout),
        .out_valid (dataout_valid),
        .out_last  (dataout_last)
    );

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_expander.sv
module tb_cnn_layer_accel_awe_stride_expander;
    import cnn_layer_accel_awe_pkg::*;

    localparam int DW = 16;
    localparam int RW = 10;
    localparam int SW = STRIDE_CNT_W;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          config_valid;
    logic [SW-1:0] stride_size;
    logic [RW-1:0] row_length;
    logic [DW-1:0] datain;
    logic          datain_valid;
    logic          datain_last;
    logic          datain_ready;
    logic [DW-1:0] dataout;
    logic          dataout_valid;
    logic          dataout_last;
    logic          dataout_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] in_d[$];
    bit            in_l[$];
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            got_c[$];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];

    always #5 clk = ~clk;

    cnn_layer_accel_awe_stride_expander dut (
        .clk           (clk),
        .rst           (rst),
        .config_valid  (config_valid),
        .stride_size   (stride_size),
        .row_length    (row_length),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_last   (datain_last),
        .datain_ready  (datain_ready),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .dataout_last  (dataout_last),
        .dataout_ready (dataout_ready)
    );

    // Called at posedge+1; returns at posedge+1 after the config cycle.
    task automatic do_config(input logic [SW-1:0] s, input logic [RW-1:0] r);
        config_valid = 1'b1;
        stride_size  = s;
        row_length   = r;
        @(posedge clk); #1;
        config_valid = 1'b0;
    endtask

    // Streams in_d/in_l into the DUT and collects n_exp output words.
    // Also checks held outputs during stalls and the datain_ready gate.
    task automatic run_stream(input int n_exp, input bit bp);
        int cyc = 0;
        bit acc;
        bit stalled = 1'b0;
        logic [DW-1:0] hd = '0;
        logic hl = 1'b0;
        got_d.delete(); got_l.delete(); got_c.delete();
        while ((in_d.size() > 0 || got_d.size() < n_exp) && cyc < BUDGET) begin
            dataout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_d.size() > 0) begin
                datain_valid = 1'b1;
                datain       = in_d[0];
                datain_last  = in_l[0];
            end else begin
                datain_valid = 1'b0;
                datain       = '0;
                datain_last  = 1'b0;
            end
            @(negedge clk);
            if (stalled) begin
                n_checks++;
                if (dataout !== hd || dataout_valid !== 1'b1 || dataout_last !== hl) begin
                    n_fail++;
                    $display("FAIL stall_hold: got data=%h valid=%b last=%b, need data=%h valid=1 last=%b",
                             dataout, dataout_valid, dataout_last, hd, hl);
                end
            end
            n_checks++;
            if (datain_ready && dataout_valid && !dataout_ready) begin
                n_fail++;
                $display("FAIL ready_gate: datain_ready=1 while output stalled, need 0");
            end
            acc = datain_valid && datain_ready;
            if (dataout_valid && dataout_ready) begin
                got_d.push_back(dataout);
                got_l.push_back(dataout_last);
                got_c.push_back(cyc);
            end
            stalled = dataout_valid && !dataout_ready;
            hd = dataout;
            hl = dataout_last;
            @(posedge clk); #1;
            if (acc) begin
                void'(in_d.pop_front());
                void'(in_l.pop_front());
            end
            cyc++;
        end
        datain_valid  = 1'b0;
        datain_last   = 1'b0;
        dataout_ready = 1'b1;
        if (cyc >= BUDGET) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d words, need %0d", got_d.size(), n_exp);
        end
        @(negedge clk);
        n_checks++;
        if (dataout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL extra_word: dataout_valid=%b after stream, need 0", dataout_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; config_valid = 1'b0; stride_size = '0; row_length = '0;
        datain = '0; datain_valid = 1'b0; datain_last = 1'b0; dataout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dataout !== '0 || dataout_valid !== 1'b0 || dataout_last !== 1'b0 || datain_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h valid=%b last=%b rdy=%b, need all 0",
                     dataout, dataout_valid, dataout_last, datain_ready);
        end
        rst = 1'b0;
        datain_valid = 1'b1;
        datain = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (datain_ready !== 1'b0 || dataout_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_accept: rdy=%b valid=%b, need 0 0", datain_ready, dataout_valid);
            end
            @(posedge clk); #1;
        end
        datain_valid = 1'b0;
    endtask

    task automatic test_reset_mid_expansion();
        do_config(3'd3, 10'd4);
        datain = 16'h0055; datain_valid = 1'b1; datain_last = 1'b0; dataout_ready = 1'b1;
        @(posedge clk); #1;
        datain_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dataout_valid !== 1'b1 || dataout !== 16'h0 || datain_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_col_entry: valid=%b data=%h rdy=%b, need 1 0000 0",
                     dataout_valid, dataout, datain_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        datain_valid = 1'b1;
        datain = 16'h0066;
        @(negedge clk);
        n_checks++;
        if (dataout !== '0 || dataout_valid !== 1'b0 || dataout_last !== 1'b0 || datain_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: data=%h valid=%b last=%b rdy=%b, need all 0",
                     dataout, dataout_valid, dataout_last, datain_ready);
        end
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (datain_ready !== 1'b0 || dataout_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stay_idle: rdy=%b valid=%b, need 0 0", datain_ready, dataout_valid);
            end
        end
        @(posedge clk); #1;
        datain_valid = 1'b0;
    endtask

    task automatic test_pass_through();
        do_config(3'd0, 10'd4);
        in_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        in_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        run_stream(exp_d.size(), 1'b0);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL pass_count: got %0d, need %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL pass_word[%0d]: got %h/%b, need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
            n_checks++;
            if (got_c[7] - got_c[0] != 7) begin
                n_fail++;
                $display("FAIL pass_rate: 8 words over %0d cycles, need 7", got_c[7] - got_c[0]);
            end
        end
    endtask

    task automatic test_column_zeros();
        do_config(3'd1, 10'd3);
        in_d = '{16'd5, 16'd6, 16'd7};
        in_l = '{0, 0, 1};
        exp_d = '{16'd5, 16'd0, 16'd6, 16'd0, 16'd7};
        exp_l = '{0, 0, 0, 0, 1};
        run_stream(exp_d.size(), 1'b0);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL col_count: got %0d, need %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL col_word[%0d]: got %h/%b, need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_2d_expansion();
        do_config(3'd2, 10'd2);
        in_d = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        in_l = '{0, 0, 0, 1};
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
        exp_d = '{16'hA, 16'h0, 16'h0, 16'hB,
                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                  16'hC, 16'h0, 16'h0, 16'hD};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
        exp_d = '{16'hA, 16'h0, 16'h0, 16'hB, 16'hC, 16'h0, 16'h0, 16'hD};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
`endif
        run_stream(exp_d.size(), 1'b0);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL exp2d_count: got %0d, need %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL exp2d_word[%0d]: got %h/%b, need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_config(3'd1, 10'd3);
        in_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        in_l = '{0, 0, 0, 0, 0, 1};
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
        exp_d = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd3,
                  16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                  16'd4, 16'd0, 16'd5, 16'd0, 16'd6};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
        exp_d = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 16'd4, 16'd0, 16'd5, 16'd0, 16'd6};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`endif
        run_stream(exp_d.size(), 1'b1);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d, need %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL bp_word[%0d]: got %h/%b, need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_reconfigure_mid_row();
        do_config(3'd1, 10'd4);
        datain = 16'h0009; datain_valid = 1'b1; datain_last = 1'b0; dataout_ready = 1'b1;
        @(posedge clk); #1;
        datain_valid = 1'b0;
        config_valid = 1'b1;
        stride_size  = 3'd3;
        row_length   = 10'd4;
        @(negedge clk);
        n_checks++;
        if (dataout_valid !== 1'b1 || dataout !== 16'h0009 || datain_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reconf_pre: valid=%b data=%h rdy=%b, need 1 0009 0",
                     dataout_valid, dataout, datain_ready);
        end
        @(posedge clk); #1;
        config_valid = 1'b0;
        n_checks++;
        if (dataout_valid !== 1'b0 || dataout !== '0 || dataout_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reconf_clear: valid=%b data=%h last=%b, need 0 0000 0",
                     dataout_valid, dataout, dataout_last);
        end
        in_d = '{16'd20, 16'd21, 16'd22, 16'd23};
        in_l = '{0, 0, 0, 1};
        exp_d = '{16'd20, 16'd0, 16'd0, 16'd0, 16'd21, 16'd0, 16'd0, 16'd0,
                  16'd22, 16'd0, 16'd0, 16'd0, 16'd23};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        run_stream(exp_d.size(), 1'b0);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL reconf_count: got %0d, need %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL reconf_word[%0d]: got %h/%b, need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_expansion();
        test_pass_through();
        test_column_zeros();
        test_2d_expansion();
        test_backpressure();
        test_reconfigure_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
